// File: rtl/sample_capture_if.sv
// Sample-path bus: raw ADC stream in, averaged sample-buffer write port out.
// "master" is the capture stage's view; "slave" is the environment's view.
interface sample_capture_if;
  logic        adc_valid;
  logic [15:0] adc_data;
  logic        sample_wr_en;
  logic [15:0] sample_wr_data;

  modport master (
    input  adc_valid,
    input  adc_data,
    output sample_wr_en,
    output sample_wr_data
  );

  modport slave (
    output adc_valid,
    output adc_data,
    input  sample_wr_en,
    input  sample_wr_data
  );
endinterface

// File: rtl/sample_capture.sv
// Armed/triggered ADC capture front-end: box-car averages 2^LOG2_DECIM samples
// per output and writes CAPTURE_LEN results into the sample buffer.
module sample_capture #(
  parameter int LOG2_DECIM  = 2,
  parameter int CAPTURE_LEN = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    trig_mode,
  input  logic [15:0]             trig_level,
  sample_capture_if.master        bus,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              state_o
);

  // Valid/ready contract: there is no back-pressure. Every cycle with
  // adc_valid=1 is one sample consumed; every cycle with sample_wr_en=1 is one
  // buffer write that the buffer must accept.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int              ACC_W    = 16 + LOG2_DECIM;
  localparam int              PH_W     = LOG2_DECIM + 1;
  localparam logic [PH_W-1:0] PH_FULL  = PH_W'(2 ** LOG2_DECIM);
  localparam logic [15:0]     LAST_IDX = 16'(CAPTURE_LEN - 1);

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [PH_W-1:0]          phase_q, phase_d;
  logic [15:0]              wr_cnt_q, wr_cnt_d;
  logic [15:0]              prev_q, prev_d;
  logic                     prev_valid_q, prev_valid_d;
  logic                     wr_en_q, wr_en_d;
  logic [15:0]              wr_data_q, wr_data_d;

  logic signed [ACC_W-1:0]  smp_ext;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  acc_sum;
  logic [PH_W-1:0]          ph_base;
  logic [PH_W-1:0]          ph_next;
  logic                     group_done;
  logic                     trig_hit;
  logic                     accept;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    phase_d      = phase_q;
    wr_cnt_d     = wr_cnt_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;

    smp_ext  = ACC_W'($signed(bus.adc_data));
    trig_hit = !trig_mode ||
               (prev_valid_q &&
                ($signed(prev_q) < $signed(trig_level)) &&
                ($signed(bus.adc_data) >= $signed(trig_level)));

    // The trigger sample starts a fresh group, so ARMED accumulates from zero.
    acc_base   = (state_q == S_CAPTURE) ? acc_q : '0;
    ph_base    = (state_q == S_CAPTURE) ? phase_q : '0;
    acc_sum    = acc_base + smp_ext;
    ph_next    = ph_base + PH_W'(1);
    group_done = (ph_next == PH_FULL);
    accept     = bus.adc_valid &&
                 ((state_q == S_CAPTURE) || ((state_q == S_ARMED) && trig_hit));

    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          state_d      = S_ARMED;
          acc_d        = '0;
          phase_d      = '0;
          wr_cnt_d     = '0;
          prev_valid_d = 1'b0;
        end
      end
      S_ARMED: begin
        if (bus.adc_valid) begin
          prev_d       = bus.adc_data;
          prev_valid_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (accept) begin
      if (group_done) begin
        wr_en_d   = 1'b1;
        // Top 16 bits of the sum == floor(acc / 2^LOG2_DECIM); cannot overflow.
        wr_data_d = acc_sum[LOG2_DECIM +: 16];
        acc_d     = '0;
        phase_d   = '0;
        wr_cnt_d  = wr_cnt_q + 16'd1;
        state_d   = (wr_cnt_q == LAST_IDX) ? S_DONE : S_CAPTURE;
      end else begin
        acc_d   = acc_sum;
        phase_d = ph_next;
        state_d = S_CAPTURE;
      end
    end

    if (abort) begin
      state_d      = S_IDLE;
      acc_d        = '0;
      phase_d      = '0;
      prev_valid_d = 1'b0;
      wr_en_d      = 1'b0;
      wr_data_d    = wr_data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      phase_q      <= '0;
      wr_cnt_q     <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      phase_q      <= phase_d;
      wr_cnt_q     <= wr_cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign bus.sample_wr_en   = wr_en_q;
  assign bus.sample_wr_data = wr_data_q;
  assign busy               = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign done               = (state_q == S_DONE);
  assign state_o            = state_q;

endmodule

// File: tb/tb_sample_capture.sv
// Bench for sample_capture: a decimating instance (LOG2_DECIM=2) and a
// pass-through instance (LOG2_DECIM=0) share control inputs; writes are scoreboarded.
module tb_sample_capture;

  logic        clk;
  logic        rst;
  logic        arm;
  logic        abort;
  logic        trig_mode;
  logic [15:0] trig_level;
  logic        busy_d, done_d, busy_p, done_p;
  logic [1:0]  state_d, state_p;

  sample_capture_if if_d ();
  sample_capture_if if_p ();

  sample_capture #(.LOG2_DECIM(2), .CAPTURE_LEN(256)) dut_d (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort),
    .trig_mode(trig_mode), .trig_level(trig_level),
    .bus(if_d), .busy(busy_d), .done(done_d), .state_o(state_d)
  );

  sample_capture #(.LOG2_DECIM(0), .CAPTURE_LEN(256)) dut_p (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort),
    .trig_mode(trig_mode), .trig_level(trig_level),
    .bus(if_p), .busy(busy_p), .done(done_p), .state_o(state_p)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q_d[$];
  logic [15:0] exp_q_p[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && if_d.sample_wr_en) begin
      if (exp_q_d.size() == 0) check("unexpected_wr_d", 32'(if_d.sample_wr_data), 32'hDEAD_BEEF);
      else check("wr_data_d", 32'(if_d.sample_wr_data), 32'(exp_q_d.pop_front()));
    end
    if (!rst && if_p.sample_wr_en) begin
      if (exp_q_p.size() == 0) check("unexpected_wr_p", 32'(if_p.sample_wr_data), 32'hDEAD_BEEF);
      else check("wr_data_p", 32'(if_p.sample_wr_data), 32'(exp_q_p.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if_d.adc_valid = 1'b0;
    if_p.adc_valid = 1'b0;
    arm            = 1'b0;
    abort          = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    step();
  endtask

  task automatic abort_pulse();
    abort = 1'b1;
    step();
  endtask

  task automatic drive_d(input logic [15:0] s);
    if_d.adc_valid = 1'b1;
    if_d.adc_data  = s;
    step();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic             trig_mode;
    logic [15:0]      trig_level;
    int               n;
    int               gap;
    logic [7:0][15:0] smp;
    int               n_exp;
    logic [1:0][15:0] exp_w;
    logic [1:0]       exp_state;
  } vec_t;

  vec_t vecs[12];
  int   n_vecs = 0;

  task automatic add_vec(input logic m, input int lvl, input int n, input int gap,
                         input int s0, input int s1, input int s2, input int s3,
                         input int s4, input int s5, input int s6, input int s7,
                         input int ne, input int e0, input int e1, input int st);
    vec_t v;
    v.trig_mode  = m;
    v.trig_level = 16'(lvl);
    v.n          = n;
    v.gap        = gap;
    v.smp[0] = 16'(s0); v.smp[1] = 16'(s1); v.smp[2] = 16'(s2); v.smp[3] = 16'(s3);
    v.smp[4] = 16'(s4); v.smp[5] = 16'(s5); v.smp[6] = 16'(s6); v.smp[7] = 16'(s7);
    v.n_exp     = ne;
    v.exp_w[0]  = 16'(e0);
    v.exp_w[1]  = 16'(e1);
    v.exp_state = 2'(st);
    vecs[n_vecs] = v;
    n_vecs++;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int g;
    trig_mode  = v.trig_mode;
    trig_level = v.trig_level;
    for (int k = 0; k < v.n_exp; k++) exp_q_d.push_back(v.exp_w[k]);
    arm_pulse();
    for (int i = 0; i < v.n; i++) begin
      if (i > 0) begin
        g = (v.gap < 0) ? int'($urandom_range(0, 5)) : v.gap;
        idle(g);
      end
      drive_d(v.smp[i]);
    end
    idle(3);
    check($sformatf("vec%0d_pending", idx), 32'(exp_q_d.size()), 32'd0);
    check($sformatf("vec%0d_state", idx), 32'(state_d), 32'(v.exp_state));
    abort_pulse();
    @(negedge clk);
    check($sformatf("vec%0d_abort_state", idx), 32'(state_d), 32'd0);
    exp_q_d.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; trig_mode = 1'b0; trig_level = '0;
    if_d.adc_valid = 1'b0; if_d.adc_data = '0;
    if_p.adc_valid = 1'b0; if_p.adc_data = '0;

    // Stimulus table: {mode, level, n, gap, samples, #writes, writes, final state}
    add_vec(0,   0, 8,  0,   1,  2,  3,  4,  5,  6,  7,  8, 2, 2, 6, 2);
    add_vec(0,   0, 4,  0,  -1, -2, -2, -2,  0,  0,  0,  0, 1, -2, 0, 2);
    add_vec(0,   0, 4,  1,  -1, -2, -2, -2,  0,  0,  0,  0, 1, -2, 0, 2);
    add_vec(0,   0, 4,  2,  -1, -2, -2, -2,  0,  0,  0,  0, 1, -2, 0, 2);
    add_vec(0,   0, 4,  3,  -1, -2, -2, -2,  0,  0,  0,  0, 1, -2, 0, 2);
    add_vec(0,   0, 4,  5,  -1, -2, -2, -2,  0,  0,  0,  0, 1, -2, 0, 2);
    add_vec(0,   0, 4, -1,  -1, -2, -2, -2,  0,  0,  0,  0, 1, -2, 0, 2);
    add_vec(1, 100, 7,  0, 150, 50, 99, 100, 10, 20, 30,  0, 1, 40, 0, 2);
    add_vec(1, 100, 7,  2, 150, 50, 99, 100, 10, 20, 30,  0, 1, 40, 0, 2);
    add_vec(1,  -5, 6,  1, -10, -6, -5,  0,  0,  3,  0,  0, 1, -1, 0, 2);
    add_vec(1,   0, 4,  0,   5,  6,  7,  8,  0,  0,  0,  0, 0,  0, 0, 1);

    // Reset state
    @(negedge clk);
    check("rst_wr_en_d",   32'(if_d.sample_wr_en),   32'd0);
    check("rst_wr_data_d", 32'(if_d.sample_wr_data), 32'd0);
    check("rst_busy_d",    32'(busy_d),              32'd0);
    check("rst_done_d",    32'(done_d),              32'd0);
    check("rst_state_d",   32'(state_d),             32'd0);
    check("rst_state_p",   32'(state_p),             32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < n_vecs; i++) run_vec(i, vecs[i]);

    // Strobe timing: one cycle wide, the cycle after the 4th valid
    trig_mode = 1'b0;
    exp_q_d.push_back(16'd4);
    arm_pulse();
    check("armed_state", 32'(state_d), 32'd1);
    check("armed_busy",  32'(busy_d),  32'd1);
    drive_d(16'd4); drive_d(16'd4); drive_d(16'd4);
    check("pre_strobe_off", 32'(if_d.sample_wr_en), 32'd0);
    drive_d(16'd4);
    @(negedge clk);
    check("strobe_on", 32'(if_d.sample_wr_en), 32'd1);
    @(negedge clk);
    check("strobe_off", 32'(if_d.sample_wr_en), 32'd0);
    check("strobe_hold_data", 32'(if_d.sample_wr_data), 32'd4);
    abort_pulse();

    // Abort mid-group discards partial sum, then re-arm
    arm_pulse();
    drive_d(16'd8); drive_d(16'd8); drive_d(16'd8);
    abort_pulse();
    @(negedge clk);
    check("abort_mid_state", 32'(state_d), 32'd0);
    idle(3);
    check("abort_mid_nowrite", 32'(exp_q_d.size()), 32'd0);
    exp_q_d.push_back(16'd8);
    arm_pulse();
    drive_d(16'd8); drive_d(16'd8); drive_d(16'd8); drive_d(16'd8);
    idle(2);
    check("rearm_pending", 32'(exp_q_d.size()), 32'd0);
    abort_pulse();
    // arm and abort together: abort wins
    arm = 1'b1; abort = 1'b1;
    step();
    @(negedge clk);
    check("arm_abort_state_d", 32'(state_d), 32'd0);
    check("arm_abort_busy_p",  32'(busy_p),  32'd0);

    // Pass-through full capture on dut_p
    trig_mode = 1'b0;
    for (int i = 0; i < 256; i++) exp_q_p.push_back(16'h1000 + 16'(i));
    arm_pulse();
    for (int i = 0; i < 256; i++) begin
      if_p.adc_valid = 1'b1;
      if_p.adc_data  = 16'h1000 + 16'(i);
      step();
    end
    @(negedge clk);
    check("last_wr_en_p", 32'(if_p.sample_wr_en), 32'd1);
    check("last_done_p",  32'(done_p),             32'd1);
    check("last_state_p", 32'(state_p),            32'd3);
    check("last_busy_p",  32'(busy_p),             32'd0);
    for (int i = 0; i < 10; i++) begin
      if_p.adc_valid = 1'b1;
      if_p.adc_data  = 16'h2000 + 16'(i);
      step();
    end
    idle(2);
    check("ramp_pending_p", 32'(exp_q_p.size()), 32'd0);
    check("done_hold_p",    32'(done_p),         32'd1);
    check("done_data_p",    32'(if_p.sample_wr_data), 32'h10FF);
    arm_pulse();
    @(negedge clk);
    check("rearm_from_done_state", 32'(state_p), 32'd1);
    check("rearm_from_done_done",  32'(done_p),  32'd0);
    abort_pulse();

    // Asynchronous reset between clock edges mid-capture
    arm_pulse();
    drive_d(16'd3); drive_d(16'd3);
    if_d.adc_valid = 1'b1; if_d.adc_data = 16'd3;
    if_p.adc_valid = 1'b1; if_p.adc_data = 16'h1234;
    exp_q_p.push_back(16'h1234);
    step();
    check("pre_rst_state_d", 32'(state_d), 32'd2);
    check("pre_rst_wr_en_p", 32'(if_p.sample_wr_en), 32'd1);
    #2;
    rst = 1'b1;
    exp_q_p.delete();
    #1;
    check("arst_wr_en_p",   32'(if_p.sample_wr_en),   32'd0);
    check("arst_wr_data_p", 32'(if_p.sample_wr_data), 32'd0);
    check("arst_state_p",   32'(state_p),             32'd0);
    check("arst_state_d",   32'(state_d),             32'd0);
    check("arst_busy_d",    32'(busy_d),              32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if_d.adc_valid = 1'b1; if_d.adc_data = 16'($urandom_range(0, 16'hFFFF));
      if_p.adc_valid = 1'b1; if_p.adc_data = 16'($urandom_range(0, 16'hFFFF));
      step();
    end
    idle(2);
    check("post_rst_state_d", 32'(state_d), 32'd0);
    check("post_rst_state_p", 32'(state_p), 32'd0);
    check("post_rst_data_p",  32'(if_p.sample_wr_data), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sample_capture.md
Name: sample_capture

Overview:
- Front-end stage directly upstream of the sample buffer. Owns the buffer's write side: sample_wr_en / sample_wr_data.
- Takes a raw signed 16-bit ADC sample stream and waits for an arm command plus an optional level trigger.
- Box-car averages each group of 2^LOG2_DECIM samples, writes exactly CAPTURE_LEN averaged samples into the buffer, then stops and flags done for the UART command/stream logic.

Parameters:
- LOG2_DECIM, 2: decimation factor = 2^LOG2_DECIM. Legal range 0..8.
- CAPTURE_LEN, 256: number of buffer writes per capture. Matches buffer depth. Legal range 1..65535.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- arm  in  1  single-cycle start request
- abort  in  1  single-cycle cancel request
- trig_mode  in  1  0 = start on first sample after arm; 1 = rising level crossing
- trig_level  in  16  signed trigger threshold
- adc_valid  in  1  adc_data qualifier, one sample per high cycle
- adc_data  in  16  signed input sample
- sample_wr_en  out  1  buffer write strobe, one cycle per output sample
- sample_wr_data  out  16  signed averaged sample
- busy  out  1  high in ARMED or CAPTURE
- done  out  1  level; high in DONE
- state_o  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3

Behaviour:
- Reset (async assert, release synchronous to clk):
  - state IDLE; sample_wr_en=0, sample_wr_data=0, busy=0, done=0.
  - accumulator, phase counter, write counter and prev-sample-valid flag all cleared.
- IDLE:
  - arm -> ARMED. Clears the write counter, accumulator and prev-valid flag.
- ARMED:
  - trig_mode=0: the first adc_valid sample triggers.
  - trig_mode=1: triggers when prev < trig_level and cur >= trig_level (signed compare). Both are raw samples; prev is the last valid sample seen in ARMED.
  - The first valid sample after arm never triggers in mode 1 (no prev yet). It only sets prev.
  - The triggering sample is the first sample accumulated. The same cycle moves to CAPTURE with acc=sample and phase=1.
- CAPTURE:
  - Each adc_valid adds the sign-extended sample to a (16+LOG2_DECIM)-bit signed accumulator.
  - When phase reaches 2^LOG2_DECIM:
    - output = acc >>> LOG2_DECIM (arithmetic shift, floor; no rounding, cannot overflow).
    - Registered: sample_wr_en=1 for exactly the cycle after the completing adc_valid.
    - Accumulator reloads from zero; write counter increments.
- LOG2_DECIM=0: pass-through. Every valid sample produces a write with latency 1, including the trigger sample.
- adc_valid gaps of any length are allowed. Phase only advances on valid cycles.
- After the CAPTURE_LEN-th write is issued -> DONE on the same edge that raises sample_wr_en. done=1 from that edge; busy=0.
- No write occurs except in CAPTURE; adc_valid is ignored in IDLE and DONE.
- DONE:
  - Holds until arm, which behaves as from IDLE and clears done.
- arm while ARMED or CAPTURE: ignored.
- abort:
  - From any state -> IDLE next edge.
  - Partial accumulation discarded; no write issued; done cleared.
  - A write already registered for that edge still completes.
- abort and arm in the same cycle: abort wins.
- sample_wr_data holds its last value when sample_wr_en=0.

Test Plan:
- Immediate mode, LOG2_DECIM=2, arm, then valid samples 1..8 -> two writes, data 2 (10>>>2) then 6 (26>>>2). Each strobe is 1 cycle, 1 cycle after the 4th/8th sample.
- LOG2_DECIM=2, samples -1,-2,-2,-2 -> single write of 0xFFFE (-7>>>2 = -2, floor). Samples with gaps of 0..5 idle cycles between valids give an identical result.
- trig_mode=1, level 100, samples after arm: 150, 50, 99, 100, 10, 20, 30 -> 150 does not trigger (no prev). Trigger on 100; first write = (100+10+20+30)>>>2 = 40.
- CAPTURE_LEN=256, LOG2_DECIM=0, ramp 0x1000+i streamed continuously -> exactly 256 writes, data 0x1000..0x10FF. done=1 and state_o=3 from the last write edge; 10 further valid samples produce no writes.
- Abort after 3 of 4 samples in a group -> no write, state_o=0 next cycle. Re-arm, then 4 samples of 8 -> one write of 8. arm+abort in the same cycle -> stays IDLE.
- Assert rst asynchronously mid-CAPTURE (between clock edges) -> all outputs 0 immediately. After release, IDLE and no writes until a new arm.
